// File: rtl/mult_div_unit_pkg.sv
// Shared CPU constants for the multiply/divide path: md_op encodings, FSM states
// and default latencies used by the decoder, stall controller and mult_div_unit.
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int MULT_CYCLES_DEFAULT = 5;
    localparam int DIV_CYCLES_DEFAULT  = 10;

    // Ops that occupy the unit for multiple cycles (mult/multu/div/divu).
    function automatic logic is_arith_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mult_div_unit_md_arith.sv
// Combinational 64-bit product and quotient/remainder for the latched operands.
// wr_en drops for a divide by zero so HI/LO keep their old values.
module md_arith
    import mult_div_unit_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        wr_en
);

    logic signed [63:0] s_prod;
    logic        [63:0] u_prod;
    logic signed [63:0] s_num;
    logic signed [63:0] s_den;
    logic signed [63:0] s_quo;
    logic signed [63:0] s_rem;
    logic        [31:0] u_den;
    logic        [31:0] u_quo;
    logic        [31:0] u_rem;
    logic               div_zero;

    // Signed divide runs at 64 bits so 0x80000000 / -1 yields 0x80000000 without overflow;
    // a zero divisor is swapped for 1 to keep the divider defined.
    always_comb begin
        div_zero = (b == 32'd0);
        s_prod   = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        u_prod   = {32'd0, a} * {32'd0, b};
        s_num    = $signed({{32{a[31]}}, a});
        s_den    = div_zero ? 64'sd1 : $signed({{32{b[31]}}, b});
        s_quo    = s_num / s_den;
        s_rem    = s_num % s_den;
        u_den    = div_zero ? 32'd1 : b;
        u_quo    = a / u_den;
        u_rem    = a % u_den;

        hi    = 32'd0;
        lo    = 32'd0;
        wr_en = 1'b0;
        case (op)
            MD_MULT: begin
                hi    = s_prod[63:32];
                lo    = s_prod[31:0];
                wr_en = 1'b1;
            end
            MD_MULTU: begin
                hi    = u_prod[63:32];
                lo    = u_prod[31:0];
                wr_en = 1'b1;
            end
            MD_DIV: begin
                hi    = s_rem[31:0];
                lo    = s_quo[31:0];
                wr_en = !div_zero;
            end
            MD_DIVU: begin
                hi    = u_rem;
                lo    = u_quo;
                wr_en = !div_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers; busy models the fixed
// latency, and results land in HI/LO on the edge busy clears.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] D1,
    input  logic [31:0] D2,
    input  logic [2:0]  md_op,
    input  logic        int_req,
    output logic        busy,
    output logic        md_pending,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e        state;
    md_state_e        next_state;
    logic [CNT_W-1:0] count;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic [2:0]       op_r;
    logic             accept;
    logic             start;
    logic             done;
    logic [31:0]      res_hi;
    logic [31:0]      res_lo;
    logic             res_wr;

    md_arith u_arith (
        .a     (op_a),
        .b     (op_b),
        .op    (op_r),
        .hi    (res_hi),
        .lo    (res_lo),
        .wr_en (res_wr)
    );

    assign busy       = (state == ST_RUN);
    assign md_pending = busy || (is_arith_op(md_op) && !int_req);

    always_comb begin
        accept     = (state == ST_IDLE) && !int_req;
        start      = accept && is_arith_op(md_op);
        done       = (state == ST_RUN) && (count == CNT_W'(1));
        next_state = state;
        case (state)
            ST_IDLE: if (start) next_state = ST_RUN;
            ST_RUN:  if (done)  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Reset aborts any in-flight op; mthi/mtlo share the idle acceptance path.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            op_a  <= 32'd0;
            op_b  <= 32'd0;
            op_r  <= 3'd0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else if (start) begin
            op_a  <= D1;
            op_b  <= D2;
            op_r  <= md_op;
            count <= is_div_op(md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (accept && (md_op == MD_MTHI)) begin
            HI <= D1;
        end else if (accept && (md_op == MD_MTLO)) begin
            LO <= D1;
        end else if (state == ST_RUN) begin
            count <= count - CNT_W'(1);
            if (done && res_wr) begin
                HI <= res_hi;
                LO <= res_lo;
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, arithmetic results, mthi/mtlo,
// int_req suppression, reset abort and back-to-back issue.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] D1;
    logic [31:0] D2;
    logic [2:0]  md_op;
    logic        int_req;
    logic        busy;
    logic        md_pending;
    logic [31:0] HI;
    logic [31:0] LO;

    int errors = 0;
    int checks = 0;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .D1         (D1),
        .D2         (D2),
        .md_op      (md_op),
        .int_req    (int_req),
        .busy       (busy),
        .md_pending (md_pending),
        .HI         (HI),
        .LO         (LO)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Counts busy cycles starting from a cycle where busy is already observed high.
    task automatic wait_done(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; md_op = 3'd0; int_req = 1'b0; D1 = 32'd0; D2 = 32'd0;
        tick(); tick();
        reset = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (HI !== 32'd0) begin errors++; $display("[TB] FAIL reset_hi: got %h expected 00000000", HI); end
        checks++; if (LO !== 32'd0) begin errors++; $display("[TB] FAIL reset_lo: got %h expected 00000000", LO); end
        checks++; if (md_pending !== 1'b0) begin errors++; $display("[TB] FAIL reset_pending: got %b expected 0", md_pending); end
    endtask

    task automatic test_mult;
        int n;
        D1 = 32'hFFFF_FFFE; D2 = 32'd3; md_op = 3'd1;
        #1;
        checks++; if (md_pending !== 1'b1) begin errors++; $display("[TB] FAIL mult_pending: got %b expected 1", md_pending); end
        tick();
        md_op = 3'd0;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL mult_busy_start: got %b expected 1", busy); end
        checks++; if (HI !== 32'd0 || LO !== 32'd0) begin errors++; $display("[TB] FAIL mult_hold: got %h_%h expected 00000000_00000000", HI, LO); end
        wait_done(n);
        checks++; if (n != 5) begin errors++; $display("[TB] FAIL mult_latency: got %0d expected 5", n); end
        checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL mult_hi: got %h expected ffffffff", HI); end
        checks++; if (LO !== 32'hFFFF_FFFA) begin errors++; $display("[TB] FAIL mult_lo: got %h expected fffffffa", LO); end

        md_op = 3'd2;
        tick();
        md_op = 3'd0;
        wait_done(n);
        checks++; if (n != 5) begin errors++; $display("[TB] FAIL multu_latency: got %0d expected 5", n); end
        checks++; if (HI !== 32'h0000_0002) begin errors++; $display("[TB] FAIL multu_hi: got %h expected 00000002", HI); end
        checks++; if (LO !== 32'hFFFF_FFFA) begin errors++; $display("[TB] FAIL multu_lo: got %h expected fffffffa", LO); end
    endtask

    task automatic test_div;
        int n;
        D1 = 32'hFFFF_FFF9; D2 = 32'd2; md_op = 3'd3;
        tick();
        md_op = 3'd0;
        wait_done(n);
        checks++; if (n != 10) begin errors++; $display("[TB] FAIL div_latency: got %0d expected 10", n); end
        checks++; if (LO !== 32'hFFFF_FFFD) begin errors++; $display("[TB] FAIL div_lo: got %h expected fffffffd", LO); end
        checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL div_hi: got %h expected ffffffff", HI); end

        D1 = 32'd7; D2 = 32'd0; md_op = 3'd4;
        tick();
        md_op = 3'd0;
        wait_done(n);
        checks++; if (n != 10) begin errors++; $display("[TB] FAIL divu0_latency: got %0d expected 10", n); end
        checks++; if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin errors++; $display("[TB] FAIL divu0_unchanged: got %h_%h expected ffffffff_fffffffd", HI, LO); end

        D1 = 32'h8000_0000; D2 = 32'hFFFF_FFFF; md_op = 3'd3;
        tick();
        md_op = 3'd0;
        wait_done(n);
        checks++; if (LO !== 32'h8000_0000 || HI !== 32'd0) begin errors++; $display("[TB] FAIL div_overflow: got %h_%h expected 00000000_80000000", HI, LO); end
    endtask

    task automatic test_mthi_mtlo;
        int n;
        D1 = 32'd2; D2 = 32'd3; md_op = 3'd1;
        tick();
        D1 = 32'h1234_5678; md_op = 3'd5;
        tick();
        md_op = 3'd0;
        checks++; if (HI !== 32'd0) begin errors++; $display("[TB] FAIL mthi_busy_ignored: got %h expected 00000000", HI); end
        wait_done(n);
        checks++; if (HI !== 32'd0 || LO !== 32'd6) begin errors++; $display("[TB] FAIL mult_small: got %h_%h expected 00000000_00000006", HI, LO); end
        md_op = 3'd5;
        tick();
        md_op = 3'd0;
        checks++; if (HI !== 32'h1234_5678 || busy !== 1'b0) begin errors++; $display("[TB] FAIL mthi_idle: got %h busy=%b expected 12345678 busy=0", HI, busy); end
        D1 = 32'hCAFE_F00D; md_op = 3'd6;
        tick();
        md_op = 3'd0;
        checks++; if (LO !== 32'hCAFE_F00D || HI !== 32'h1234_5678) begin errors++; $display("[TB] FAIL mtlo_idle: got %h_%h expected 12345678_cafef00d", HI, LO); end
    endtask

    task automatic test_int_req;
        int n;
        D1 = 32'd5; D2 = 32'd5; md_op = 3'd1; int_req = 1'b1;
        #1;
        checks++; if (md_pending !== 1'b0) begin errors++; $display("[TB] FAIL int_pending: got %b expected 0", md_pending); end
        tick();
        md_op = 3'd0; int_req = 1'b0;
        checks++; if (busy !== 1'b0 || HI !== 32'h1234_5678 || LO !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL int_suppress: got busy=%b %h_%h expected busy=0 12345678_cafef00d", busy, HI, LO); end

        D1 = 32'hFFFF_FFFE; D2 = 32'd3; md_op = 3'd1;
        tick();
        md_op = 3'd0;
        tick();
        int_req = 1'b1; md_op = 3'd3;
        tick();
        int_req = 1'b0; md_op = 3'd0;
        wait_done(n);
        checks++; if (n + 2 != 5) begin errors++; $display("[TB] FAIL int_inflight_latency: got %0d expected 5", n + 2); end
        checks++; if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA) begin errors++; $display("[TB] FAIL int_inflight_result: got %h_%h expected ffffffff_fffffffa", HI, LO); end
    endtask

    task automatic test_reset_abort;
        D1 = 32'd100; D2 = 32'd7; md_op = 3'd3;
        tick();
        md_op = 3'd0;
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin errors++; $display("[TB] FAIL reset_abort: got busy=%b %h_%h expected busy=0 00000000_00000000", busy, HI, LO); end
        for (int i = 0; i < 12; i++) tick();
        checks++; if (HI !== 32'd0 || LO !== 32'd0) begin errors++; $display("[TB] FAIL reset_no_write: got %h_%h expected 00000000_00000000", HI, LO); end

        D1 = 32'h0000_AAAA; md_op = 3'd5; reset = 1'b1;
        tick();
        reset = 1'b0; md_op = 3'd0;
        checks++; if (HI !== 32'd0) begin errors++; $display("[TB] FAIL reset_priority: got %h expected 00000000", HI); end
    endtask

    task automatic test_back_to_back;
        int  n;
        logic pend_ok;
        pend_ok = 1'b1;
        D1 = 32'hFFFF_FFFE; D2 = 32'd3; md_op = 3'd1;
        tick();
        D1 = 32'hFFFF_FFF9; D2 = 32'd2; md_op = 3'd3;
        n = 0;
        while (busy && n < 100) begin
            if (md_pending !== 1'b1) pend_ok = 1'b0;
            n++;
            tick();
        end
        checks++; if (n != 5) begin errors++; $display("[TB] FAIL b2b_mult_latency: got %0d expected 5", n); end
        checks++; if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA) begin errors++; $display("[TB] FAIL b2b_mult_result: got %h_%h expected ffffffff_fffffffa", HI, LO); end
        if (md_pending !== 1'b1) pend_ok = 1'b0;
        tick();
        md_op = 3'd0;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_div_accept: got %b expected 1", busy); end
        n = 0;
        while (busy && n < 100) begin
            if (md_pending !== 1'b1) pend_ok = 1'b0;
            n++;
            tick();
        end
        checks++; if (pend_ok !== 1'b1) begin errors++; $display("[TB] FAIL b2b_pending_continuous: got %b expected 1", pend_ok); end
        checks++; if (n != 10) begin errors++; $display("[TB] FAIL b2b_div_latency: got %0d expected 10", n); end
        checks++; if (LO !== 32'hFFFF_FFFD || HI !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL b2b_div_result: got %h_%h expected ffffffff_fffffffd", HI, LO); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_int_req();
        test_reset_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: cycles busy is high after a mult/multu request.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: cycles busy is high after a div/divu request.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port D1  input  32  forwarded rs operand from the E-stage forwarding mux.
REQ-006 SHALL have port D2  input  32  forwarded rt operand from the E-stage forwarding mux.
REQ-007 SHALL have port md_op  input  3  E-stage request: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-008 SHALL have port int_req  input  1  interrupt/exception taken this cycle; suppresses any request in the same cycle.
REQ-009 SHALL have port busy  output  1  high while an operation is in flight.
REQ-010 SHALL have port md_pending  output  1  combinational busy OR (md_op in 1..4 AND NOT int_req), for the stall controller.
REQ-011 SHALL have port HI  output  32  registered HI register value.
REQ-012 SHALL have port LO  output  32  registered LO register value.

Function
REQ-013 SHALL accept a request only when busy=0 and int_req=0; requests arriving while busy=1 or int_req=1 SHALL be ignored with no state change.
REQ-014 SHALL, on an accepted mult/multu/div/divu, latch D1, D2 and the op at that edge, load the counter with MULT_CYCLES or DIV_CYCLES, and set busy=1 from the next cycle.
REQ-015 SHALL decrement the counter each cycle while busy; on the edge where the counter goes 1->0 it SHALL write HI/LO and clear busy in the same edge.
REQ-016 SHALL therefore hold busy high for exactly MULT_CYCLES (mult) or DIV_CYCLES (div) cycles, with the new HI/LO visible in the first cycle busy=0.
REQ-017 SHALL keep HI/LO at their old values throughout busy.
REQ-018 SHALL compute mult as the signed 32x32 -> 64 product and multu as the unsigned product; HI = bits 63:32, LO = bits 31:0.
REQ-019 SHALL compute div/divu as signed/unsigned D1/D2: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
REQ-020 SHALL run the full DIV_CYCLES for a divide by zero (D2=0) but leave HI/LO unchanged at completion.
REQ-021 SHALL give signed 0x80000000 / 0xFFFFFFFF the result LO=0x80000000, HI=0.
REQ-022 SHALL, on an accepted mthi/mtlo, write D1 into HI/LO at that edge with no busy cycle.
REQ-023 SHALL let an operation already in flight complete normally when int_req rises; int_req only cancels same-cycle requests.
REQ-024 SHALL have two states, IDLE (busy=0) and RUN (busy=1): IDLE->RUN on an accepted mult/div, RUN->IDLE on the counter reaching 0, RUN->RUN otherwise.

Reset
REQ-025 SHALL, when reset=1 at an edge, set HI=0, LO=0, busy=0, counter=0, latched operands=0 and state=IDLE, aborting any operation in flight with no HI/LO write.
REQ-026 SHALL give reset priority over any request in the same cycle.

Structure
REQ-027 SHALL take the md_op encodings and the MULT_CYCLES/DIV_CYCLES defaults from the shared CPU constants package, which the decoder and the stall controller also use.
REQ-028 SHALL place the 64-bit product and quotient/remainder arithmetic in one combinational sub-module, md_arith; the counter, state and HI/LO registers stay in mult_div_unit.

Verification
REQ-029 SHALL cover: mult with D1=0xFFFFFFFE (-2), D2=3 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-030 SHALL cover: div with D1=-7, D2=2 -> busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu with D1=7, D2=0 -> busy high 10 cycles, HI/LO unchanged.
REQ-031 SHALL cover: mthi with D1=0x12345678 while busy=1 -> ignored; the same request when idle -> HI=0x12345678 on the next cycle.
REQ-032 SHALL cover: mult with int_req=1 in the same cycle -> busy stays 0, md_pending=0, HI/LO unchanged; int_req=1 during cycle 3 of a running mult -> result still written at cycle 5.
REQ-033 SHALL cover: reset asserted during cycle 4 of a div -> busy=0, HI=LO=0 on the next cycle, no later HI/LO write.
REQ-034 SHALL cover: back-to-back requests, a mult accepted and a div presented on the cycle busy falls -> the div is accepted, and md_pending stays high continuously.
